// File: rtl/fpcvt_pkg.sv
// Shared state encodings and rounding-mode constants for the
// integer-to-float converter.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

endpackage

// File: rtl/fp_round.sv
// Combinational round-half-up stage: increments the significand on a set
// guard bit, carrying into the exponent or saturating at the top of range.
module fp_round
    import fpcvt_pkg::*;
#(
    parameter int unsigned EW = 3,
    parameter int unsigned MW = 5
) (
    input  logic [MW-1:0] i_f,
    input  logic [EW-1:0] i_e,
    input  logic          i_guard,
    input  rnd_mode_e     i_mode,
    output logic [MW-1:0] o_f,
    output logic [EW-1:0] o_e,
    output logic          o_ovf
);

    localparam logic [MW-1:0] F_CARRY = MW'(1) << (MW - 1);

    always_comb begin
        o_f   = i_f;
        o_e   = i_e;
        o_ovf = 1'b0;
        if (i_mode == RND_HALF_UP && i_guard) begin
            if (i_f != '1) begin
                o_f = i_f + 1'b1;
            end else if (i_e != '1) begin
                // Significand wraps to 1.00..0 with one more power of two.
                o_f = F_CARRY;
                o_e = i_e + 1'b1;
            end else begin
                o_ovf = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to sign/exponent/significand converter:
// one normalising shift per cycle, then an optional rounding step.
module fp_convert_seq
    import fpcvt_pkg::*;
#(
    parameter int unsigned DW = 13,
    parameter int unsigned EW = 3,
    parameter int unsigned MW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_ovf
);

    localparam int unsigned MAGW = DW - 1;
    localparam int unsigned GB   = DW - 2 - MW;

    if (DW != MW + (1 << EW)) begin : g_param_check
        $error("fp_convert_seq: DW must equal MW + 2**EW");
    end

    state_e          r_state;
    logic            r_s;
    rnd_mode_e       r_mode;
    logic [MAGW-1:0] r_mag;
    logic [EW-1:0]   r_e;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_out_s;
    logic [EW-1:0]   r_out_e;
    logic [MW-1:0]   r_out_f;
    logic            r_out_ovf;

    logic [MAGW-1:0] w_abs;
    logic [MW-1:0]   w_rnd_f;
    logic [EW-1:0]   w_rnd_e;
    logic            w_rnd_ovf;

    // The most negative input has no positive counterpart; clamp to all ones.
    always_comb begin
        w_abs = in_data[MAGW-1:0];
        if (in_data[DW-1]) begin
            if (in_data[MAGW-1:0] == '0) begin
                w_abs = '1;
            end else begin
                w_abs = ~in_data[MAGW-1:0] + 1'b1;
            end
        end
    end

    fp_round #(
        .EW (EW),
        .MW (MW)
    ) u_round (
        .i_f     (r_mag[MAGW-1 -: MW]),
        .i_e     (r_e),
        .i_guard (r_mag[GB]),
        .i_mode  (r_mode),
        .o_f     (w_rnd_f),
        .o_e     (w_rnd_e),
        .o_ovf   (w_rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s         <= 1'b0;
            r_mode      <= RND_TRUNC;
            r_mag       <= '0;
            r_e         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_s     <= 1'b0;
            r_out_e     <= '0;
            r_out_f     <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s        <= in_data[DW-1];
                        r_mode     <= rnd_mode_e'(in_rnd);
                        r_mag      <= w_abs;
                        r_e        <= '1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_e == '0 || r_mag[MAGW-1]) begin
                        r_state <= ST_RND;
                    end else begin
                        r_mag <= {r_mag[MAGW-2:0], 1'b0};
                        r_e   <= r_e - 1'b1;
                    end
                end
                ST_RND: begin
                    r_out_s     <= r_s;
                    r_out_e     <= w_rnd_e;
                    r_out_f     <= w_rnd_f;
                    r_out_ovf   <= w_rnd_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    // Handshake cycle only returns to IDLE; acceptance starts next cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_e     = r_out_e;
    assign out_f     = r_out_f;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fp_convert_seq.sv
// Scoreboard bench for fp_convert_seq: the driver queues hand-computed
// results, a monitor pops and compares them whenever a result appears.
module tb_fp_convert_seq;

    localparam int unsigned DW = 13;
    localparam int unsigned EW = 3;
    localparam int unsigned MW = 5;

    typedef struct {
        int d;
        bit r;
        bit s;
        int e;
        int f;
        bit ovf;
        int lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_rnd;
    logic          out_valid;
    logic          out_ready;
    logic          out_s;
    logic [EW-1:0] out_e;
    logic [MW-1:0] out_f;
    logic          out_ovf;

    exp_t q[$];
    exp_t cur;
    bit   have_cur;
    logic prev_ov;
    int   errors;
    int   checks;
    int   cyc;

    fp_convert_seq #(
        .DW (DW),
        .EW (EW),
        .MW (MW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: a rising out_valid consumes one expected entry; every cycle
    // the result is held it must still match that entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_in_out", int'(in_ready), 0);
                if (!prev_ov) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_result: got e=%0d f=%0d expected none (cycle %0d)",
                                 out_e, out_f, cyc);
                    end else begin
                        cur      = q.pop_front();
                        have_cur = 1'b1;
                        chk("latency", cyc - cur.acc, cur.v.lat);
                    end
                end
                if (have_cur) begin
                    chk("out_s", int'(out_s), int'(cur.v.s));
                    chk("out_e", int'(out_e), cur.v.e);
                    chk("out_f", int'(out_f), cur.v.f);
                    chk("out_ovf", int'(out_ovf), int'(cur.v.ovf));
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input vec_t v, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
            return;
        end
        in_valid = 1'b1;
        in_data  = DW'(v.d);
        in_rnd   = v.r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_rnd   = 1'($urandom);
        if (push) q.push_back('{v: v, acc: cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    vec_t vecs[13] = '{
        '{d:   422, r: 1, s: 0, e: 4, f: 'b11010, ovf: 0, lat: 5},
        '{d:   126, r: 1, s: 0, e: 3, f: 'b10000, ovf: 0, lat: 7},
        '{d:   126, r: 0, s: 0, e: 2, f: 'b11111, ovf: 0, lat: 7},
        '{d: -4096, r: 1, s: 1, e: 7, f: 'b11111, ovf: 1, lat: 2},
        '{d:  4095, r: 1, s: 0, e: 7, f: 'b11111, ovf: 1, lat: 2},
        '{d:  4095, r: 0, s: 0, e: 7, f: 'b11111, ovf: 0, lat: 2},
        '{d:     0, r: 1, s: 0, e: 0, f: 'b00000, ovf: 0, lat: 9},
        '{d:  -422, r: 1, s: 1, e: 4, f: 'b11010, ovf: 0, lat: 5},
        '{d:  2047, r: 1, s: 0, e: 7, f: 'b10000, ovf: 0, lat: 3},
        '{d:   102, r: 1, s: 0, e: 2, f: 'b11010, ovf: 0, lat: 7},
        '{d:   102, r: 0, s: 0, e: 2, f: 'b11001, ovf: 0, lat: 7},
        '{d:     1, r: 1, s: 0, e: 0, f: 'b00001, ovf: 0, lat: 9},
        '{d:    -1, r: 1, s: 1, e: 0, f: 'b00001, ovf: 0, lat: 9}
    };

    initial begin
        vec_t v;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        have_cur  = 1'b0;
        prev_ov   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_s", int'(out_s), 0);
        chk("rst_out_e", int'(out_e), 0);
        chk("rst_out_f", int'(out_f), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        foreach (vecs[i]) send(vecs[i], 1'b1);
        drain();

        // Backpressure with ignored in_valid pulses, including during the handshake edge.
        @(negedge clk);
        out_ready = 1'b0;
        send(vecs[0], 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            in_valid = 1'b1;
            in_data  = DW'(126 + i);
            in_rnd   = 1'b0;
        end
        chk("bp_out_valid_held", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_after_handshake", int'(out_valid), 0);
        chk("bp_idle_ready", int'(in_ready), 1);
        send(vecs[7], 1'b1);
        drain();

        // Reset mid-conversion: outputs clear at once, abandoned sample never emerges.
        v = '{d: 422, r: 1, s: 0, e: 4, f: 'b11010, ovf: 0, lat: 5};
        send(v, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_s", int'(out_s), 0);
        chk("midrst_out_e", int'(out_e), 0);
        chk("midrst_out_f", int'(out_f), 0);
        chk("midrst_out_ovf", int'(out_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        repeat (15) @(negedge clk);
        send(vecs[1], 1'b1);
        drain();
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_convert_seq.md
FP_CONVERT_SEQ -- requirements
Module: fp_convert_seq

Interface
REQ-001 Parameter DW, default 13: input two's-complement width.
REQ-002 Parameter EW, default 3: exponent width.
REQ-003 Parameter MW, default 5: significand width; elaboration SHALL fail unless DW == MW + 2**EW.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block can accept a sample.
REQ-008 in_data  in  DW  two's-complement sample.
REQ-009 in_rnd  in  1  rounding mode: 0 truncate, 1 round-half-up on guard bit.
REQ-010 out_valid  out  1  result registers hold a valid result.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_s  out  1  sign.
REQ-013 out_e  out  EW  exponent.
REQ-014 out_f  out  MW  significand; value = out_f * 2**out_e.
REQ-015 out_ovf  out  1  result saturated to max representable magnitude.

Function
REQ-016 States IDLE, NORM, RND, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-017 IDLE: on in_valid at edge, register S=in_data[DW-1], mode=in_rnd, mag=|in_data| in DW-1 bits (most negative input saturates mag to all ones), E=2**EW-1; go NORM.
REQ-018 NORM, one decision per cycle: if E==0 or mag[DW-2]==1 go RND; else mag<<=1 (zero fill), E-=1, stay.
REQ-019 RND: F=mag[DW-2:DW-1-MW], guard=mag[DW-2-MW]; if mode=0 or guard=0, F unchanged.
REQ-020 RND round-up: if F!=all ones, F+=1; else if E<max, F=10..0 and E+=1; else F=all ones, E=max, ovf=1.
REQ-021 RND registers out_s/out_e/out_f/out_ovf and goes OUT; out_ovf=0 for every unsaturated result.
REQ-022 Latency: with k shifts, out_valid SHALL rise k+2 cycles after the accepting edge; k in 0..2**EW-1.
REQ-023 OUT: outputs held stable while out_ready=0; on out_valid&out_ready go IDLE next cycle; no accept in the same cycle as output handshake.
REQ-024 in_valid outside IDLE SHALL be ignored; in_data/in_rnd are sampled only at the accepting edge.
REQ-025 Zero input SHALL yield S=0, E=0, F=0 after 2**EW-1 shifts.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, out_s=0, out_e=0, out_f=0, out_ovf=0, internal mag/E/mode cleared.
REQ-027 Reset asserted mid-NORM/RND/OUT SHALL abandon the conversion; no result emitted after release.

Structure
REQ-028 Shared package fpcvt_pkg SHALL hold state encodings and rounding-mode constants (RND_TRUNC=0, RND_HALF_UP=1).
REQ-029 One combinational sub-module fp_round (inputs F, E, guard, mode; outputs F', E', ovf) SHALL implement REQ-019/020; everything else lives in fp_convert_seq.
REQ-030 Implementation target 120-400 RTL lines; no latches; outputs from registers only.

Verification (defaults DW=13, EW=3, MW=5)
REQ-031 in_data=422, in_rnd=1 -> S=0, E=4, F=11010, ovf=0, out_valid 5 cycles after accept.
REQ-032 in_data=126, in_rnd=1 -> significand carry: S=0, E=3, F=10000, ovf=0, latency 7; in_rnd=0 -> E=2, F=11111.
REQ-033 in_data=-4096 and in_data=4095, in_rnd=1 -> E=7, F=11111, ovf=1 (S=1 / S=0), latency 2; 4095 with in_rnd=0 -> ovf=0.
REQ-034 in_data=0 -> S=0, E=0, F=0, ovf=0, latency 9.
REQ-035 Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses with new data ignored; next result matches only post-handshake sample.
REQ-036 rst_n pulsed low mid-NORM -> out_valid=0 and all outputs 0 immediately; next accepted sample converts correctly.
